// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------
// pipe_pkg : shared pipeline constants and the fetch-queue entry type
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam int PC_STEP_DEFAULT = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/wrap_ptr.sv
// ---------------------------------------------------------------
// wrap_ptr : modulo-DEPTH pointer with enable and synchronous clear
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module wrap_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_i,
  input  logic                     clr_i,
  output logic [$clog2(DEPTH)-1:0] ptr_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // DEPTH is a power of two, so natural overflow gives the wrap
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)     ptr_d = '0;
    else if (en_i) ptr_d = ptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------
// if_id_buffer : DEPTH-entry elastic IF/ID queue with flush and restart PC
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module if_id_buffer
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4,
  parameter int PC_STEP = PC_STEP_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [PC_W-1:0]            NextPC_if,
  input  logic [DATA_W-1:0]          Instruction_if,
  input  logic                       IF_flush,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [PC_W-1:0]            NextPC_id,
  output logic [DATA_W-1:0]          Instruction_id,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr;
  } slot_t;

  slot_t           mem_q [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [PC_W-1:0] bubble_pc_q, bubble_pc_d;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;
  slot_t           head;

  assign if_ready = (count_q < CW'(DEPTH));
  assign id_valid = (count_q != '0);
  assign push     = if_valid & if_ready & ~IF_flush;
  assign pop      = id_valid & id_ready & ~IF_flush;
  assign head     = mem_q[rd_ptr];

  wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (push),
    .clr_i (IF_flush),
    .ptr_o (wr_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (pop),
    .clr_i (IF_flush),
    .ptr_o (rd_ptr)
  );

  // Flush wins; the restart PC points back at the instruction that was being fetched
  always_comb begin
    count_d     = count_q;
    bubble_pc_d = bubble_pc_q;
    if (IF_flush) begin
      count_d     = '0;
      bubble_pc_d = NextPC_if - PC_W'(PC_STEP);
    end else begin
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (pop) bubble_pc_d = head.pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      bubble_pc_q <= '0;
    end else begin
      count_q     <= count_d;
      bubble_pc_q <= bubble_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= '{pc: NextPC_if, instr: Instruction_if};
  end

  assign NextPC_id      = id_valid ? head.pc : bubble_pc_q;
  assign Instruction_id = id_valid ? head.instr : DATA_W'(NOP_INSTR);
  assign count          = count_q;

endmodule

`default_nettype wire

// File: tb/tb_if_id_buffer.sv
// ---------------------------------------------------------------
// tb_if_id_buffer : directed table plus randomized queue-model checks
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] NextPC_if = '0;
  logic [31:0] Instruction_if = '0;
  logic        IF_flush = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] NextPC_id;
  logic [31:0] Instruction_id;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_id_buffer #(.DATA_W(32), .PC_W(32), .DEPTH(4), .PC_STEP(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .NextPC_if      (NextPC_if),
    .Instruction_if (Instruction_if),
    .IF_flush       (IF_flush),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .NextPC_id      (NextPC_id),
    .Instruction_id (Instruction_id),
    .count          (count)
  );

  // Reference model: a plain FIFO of {pc, instr} plus the last-restart PC
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_bubble = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("m_count",    64'(count),    64'(n));
    chk("m_id_valid", 64'(id_valid), 64'(n > 0));
    chk("m_if_ready", 64'(if_ready), 64'(n < 4));
    chk("m_instr",    64'(Instruction_id), (n > 0) ? 64'(mq[0].ins) : 64'h0);
    chk("m_pc",       64'(NextPC_id),      (n > 0) ? 64'(mq[0].pc)  : 64'(m_bubble));
  endtask

  task automatic model_edge(input logic v, input logic r, input logic f,
                            input logic [31:0] pc, input logic [31:0] ins);
    bit do_push, do_pop;
    if (f) begin
      mq.delete();
      m_bubble = pc - 32'd4;
    end else begin
      do_pop  = (mq.size() > 0) && r;
      do_push = v && (mq.size() < 4);
      if (do_pop) begin
        m_bubble = mq[0].pc;
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back('{pc: pc, ins: ins});
    end
  endtask

  task automatic step(input logic v, input logic r, input logic f,
                      input logic [31:0] pc, input logic [31:0] ins);
    if_valid = v; id_ready = r; IF_flush = f; NextPC_if = pc; Instruction_if = ins;
    @(posedge clk);
    model_edge(v, r, f, pc, ins);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    if_valid = 1'b0; id_ready = 1'b0; IF_flush = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    mq.delete();
    m_bubble = '0;
  endtask

  typedef struct {
    logic        v, r, f;
    logic [31:0] pc, ins;
    logic        e_valid;
    logic [2:0]  e_count;
    logic [31:0] e_pc, e_ins;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 0, 0, 32'h00400004, 32'h20080001, 1, 1, 32'h00400004, 32'h20080001};
    tbl[1]  = '{0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h00400004, 32'h20080001};
    tbl[2]  = '{0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h00400004, 32'h20080001};
    tbl[3]  = '{0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h00400004, 32'h20080001};
    tbl[4]  = '{0, 1, 0, 32'h0,        32'h0,        0, 0, 32'h00400004, 32'h0};
    tbl[5]  = '{1, 0, 0, 32'h00400008, 32'h11111111, 1, 1, 32'h00400008, 32'h11111111};
    tbl[6]  = '{1, 0, 0, 32'h0040000C, 32'h22222222, 1, 2, 32'h00400008, 32'h11111111};
    tbl[7]  = '{1, 0, 0, 32'h00400010, 32'h33333333, 1, 3, 32'h00400008, 32'h11111111};
    tbl[8]  = '{1, 1, 1, 32'h00400020, 32'hDEADBEEF, 0, 0, 32'h0040001C, 32'h0};
    tbl[9]  = '{1, 1, 0, 32'h00400024, 32'h44444444, 1, 1, 32'h00400024, 32'h44444444};
    tbl[10] = '{1, 1, 0, 32'h00400028, 32'h55555555, 1, 1, 32'h00400028, 32'h55555555};
    tbl[11] = '{0, 1, 0, 32'h0,        32'h0,        0, 0, 32'h00400028, 32'h0};

    do_reset();
    #1;
    chk("rst_id_valid", 64'(id_valid), 64'h0);
    chk("rst_if_ready", 64'(if_ready), 64'h1);
    chk("rst_count",    64'(count),    64'h0);
    chk("rst_pc",       64'(NextPC_id), 64'h0);
    chk("rst_instr",    64'(Instruction_id), 64'h0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].pc, tbl[i].ins);
      chk($sformatf("tbl%0d_valid", i), 64'(id_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_count", i), 64'(count),    64'(tbl[i].e_count));
      chk($sformatf("tbl%0d_pc", i),    64'(NextPC_id), 64'(tbl[i].e_pc));
      chk($sformatf("tbl%0d_instr", i), 64'(Instruction_id), 64'(tbl[i].e_ins));
    end

    // Fill/drain rounds, 5th push must be dropped, order preserved across wrap
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 0; i < 5; i++)
        step(1, 0, 0, 32'h00410000 + 32'(rnd * 64 + i * 4), 32'(rnd * 16 + i));
      chk("full_count", 64'(count), 64'd4);
      chk("full_if_ready", 64'(if_ready), 64'h0);
      for (int i = 0; i < 4; i++) begin
        chk("drain_order", 64'(Instruction_id), 64'(rnd * 16 + i));
        step(0, 1, 0, 32'h0, 32'h0);
      end
      chk("drain_empty", 64'(id_valid), 64'h0);
      step(1, 0, 0, 32'h00420000 + 32'(rnd), 32'hA0 + 32'(rnd));
      step(0, 1, 0, 32'h0, 32'h0);
    end

    // Steady stream: one in, one out every cycle
    step(1, 1, 0, 32'h00500000, 32'hB000);
    for (int i = 1; i <= 20; i++) begin
      step(1, 1, 0, 32'h00500000 + 32'(i * 4), 32'hB000 + 32'(i));
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_instr", 64'(Instruction_id), 64'hB000 + 64'(i));
    end
    step(0, 1, 0, 32'h0, 32'h0);

    // Async reset mid-push with two entries queued
    step(1, 0, 0, 32'h00600000, 32'hC0);
    step(1, 0, 0, 32'h00600004, 32'hC1);
    if_valid = 1'b1; NextPC_if = 32'h00600008; Instruction_if = 32'hC2;
    #2 reset = 1'b1;
    #1;
    chk("areset_count", 64'(count), 64'h0);
    chk("areset_valid", 64'(id_valid), 64'h0);
    chk("areset_pc",    64'(NextPC_id), 64'h0);
    chk("areset_instr", 64'(Instruction_id), 64'h0);
    chk("areset_ready", 64'(if_ready), 64'h1);
    do_reset();
    step(0, 0, 0, 32'h0, 32'h0);
    chk("areset_lost", 64'(id_valid), 64'h0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), $urandom, $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/if_id_buffer.md
# if_id_buffer

Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry elastic instruction queue between fetch and decode with valid/ready handshakes on both sides. It decouples fetch from decode stalls and supports a single-cycle flush that cancels every queued instruction. On flush it records a restart PC equal to the incoming NextPC minus one instruction step, so exception logic can still load EPC. It replaces the IF/ID register in the five-stage MIPS pipeline.

## Interface
Parameters:
- DATA_W, 32, instruction width
- PC_W, 32, PC width
- DEPTH, 4, queue entries; power of two, ≥ 2
- PC_STEP, 4, byte step subtracted from NextPC_if on flush

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  queue accepts; = (count < DEPTH)
- NextPC_if  in  PC_W  PC+4 of the fetched instruction
- Instruction_if  in  DATA_W  fetched instruction
- IF_flush  in  1  cancel all queued and incoming instructions (J/JR/branch/exception)
- id_valid  out  1  head entry valid
- id_ready  in  1  decode consumes head (= ~stall)
- NextPC_id  out  PC_W  head PC, or bubble PC when empty
- Instruction_id  out  DATA_W  head instruction, or 0 (NOP) when empty
- count  out  $clog2(DEPTH+1)  occupancy

## Operation
- push = if_valid & if_ready & ~IF_flush; pop = id_valid & id_ready & ~IF_flush.
- Storage: DEPTH×(PC_W+DATA_W) array, write pointer wr_ptr, read pointer rd_ptr, both $clog2(DEPTH) bits, wrapping modulo DEPTH naturally; count tracked separately (distinguishes full from empty).
- push: mem[wr_ptr] ← {NextPC_if, Instruction_if}; wr_ptr+1.
- pop: rd_ptr+1; bubble_pc ← mem[rd_ptr].pc.
- push & pop same cycle: both pointers advance, count unchanged; legal whenever 0 < count < DEPTH. When full, if_ready=0, so no push (no pass-through); when empty, no pop.
- IF_flush (highest priority after reset): wr_ptr, rd_ptr, count ← 0; bubble_pc ← NextPC_if − PC_STEP (mod 2^PC_W); incoming instruction discarded regardless of if_valid.
- Outputs: count>0 → id_valid=1, NextPC_id/Instruction_id = mem[rd_ptr]. count==0 → id_valid=0, Instruction_id=0, NextPC_id=bubble_pc.
- Storage contents are not reset; only pointers, count, bubble_pc.

## Timing
- Reset (async assert, sampled release): if_ready=1, id_valid=0, count=0, NextPC_id=0, Instruction_id=0.
- Latency: push at edge t into empty queue → id_valid=1 with that data after edge t (visible in cycle t+1). No combinational if→id path.
- if_ready depends on count only (registered state), never on id_ready.
- id_valid/head data stable while id_ready=0 (stall holds head).
- Flush at edge t: from cycle t+1 id_valid=0, count=0, NextPC_id = NextPC_if(t) − PC_STEP, if_ready=1.
- Reset asserted mid-operation: all state cleared immediately, no pending push/pop completes.

## Structure
- Shared package pipe_pkg: PC_STEP default, NOP_INSTR = 0, entry struct {pc, instr}.
- One sub-module: wrap_ptr (parametrised modulo-DEPTH pointer with enable and synchronous clear, async reset), instantiated for wr_ptr and rd_ptr.
- Count, bubble_pc, and output mux in the top level.

## Test plan
- Reset then idle: id_valid=0, NextPC_id=0, Instruction_id=0, if_ready=1, count=0.
- Push 0x00400004/0x20080001 with id_ready=0: next cycle id_valid=1 with that pair; held for 3 stall cycles; pop → id_valid=0, NextPC_id=0x00400004.
- Fill DEPTH=4 with id_ready=0: count=4, if_ready=0; a 5th if_valid is ignored; drain yields entries in order; pointers wrap correctly over 3 fill/drain rounds.
- Steady stream, if_valid=id_ready=1 for 20 cycles: count stays 1, one instruction per cycle, in order, none lost.
- Queue holds 3 entries, IF_flush with NextPC_if=0x00400020, if_valid=1: next cycle count=0, id_valid=0, Instruction_id=0, NextPC_id=0x0040001C.
- Reset asserted asynchronously mid-push with count=2: outputs reach reset values before next edge; the pushed entry is never seen.
